// File: rtl/sram_host_loader.sv
// Host-side loader for a corelet: streams ACT and W words into their SRAMs,
// kicks the corelet, then reads OP results back through a valid/ready port.
module sram_host_loader #(
  parameter int unsigned ACT_WORDS = 36,
  parameter int unsigned W_WORDS   = 72,
  parameter int unsigned OP_BASE   = 0,
  parameter int unsigned OP_WORDS  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic [31:0]  dut_ACT_d,
  output logic [6:0]   dut_ACT_addr,
  output logic         dut_ACT_cen,
  output logic         dut_ACT_wen,
  output logic [31:0]  dut_W_d,
  output logic [6:0]   dut_W_addr,
  output logic         dut_W_cen,
  output logic         dut_W_wen,
  input  logic [127:0] dut_OP_q,
  output logic [8:0]   dut_OP_addr,
  output logic         dut_OP_cen,
  output logic         dut_OP_wen,
  output logic [127:0] dut_OP_d,
  output logic         dut_cl_sel,
  output logic         seq_begin,
  input  logic         seq_done
);

  // Handshakes: in_data moves on a cycle with in_valid & in_ready; out_data
  // moves on a cycle with out_valid & out_ready. Neither side may retract
  // valid data before its handshake, and out_data is frozen while waiting.

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_WORDS - 1);
  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(W_WORDS - 1);
  localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(OP_WORDS - 1);
  localparam logic [8:0]       OP_BASE9 = 9'(OP_BASE);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_ACT,
    LOAD_W,
    KICK,
    WAIT,
    RD_REQ,
    RD_CAP,
    RD_HOLD,
    FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    in_ready     = 1'b0;
    done         = 1'b0;
    seq_begin    = 1'b0;
    dut_cl_sel   = 1'b1;
    dut_ACT_d    = '0;
    dut_ACT_addr = '0;
    dut_ACT_cen  = 1'b1;
    dut_ACT_wen  = 1'b1;
    dut_W_d      = '0;
    dut_W_addr   = '0;
    dut_W_cen    = 1'b1;
    dut_W_wen    = 1'b1;
    dut_OP_addr  = '0;
    dut_OP_cen   = 1'b1;

    // Outputs are combinational, so reset masks them to keep the reset
    // cycle itself free of SRAM traffic and handshakes.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD_ACT;
            cnt_d   = '0;
          end
        end
        LOAD_ACT: begin
          in_ready = 1'b1;
          if (in_valid) begin
            dut_ACT_cen  = 1'b0;
            dut_ACT_wen  = 1'b0;
            dut_ACT_addr = cnt_q[6:0];
            dut_ACT_d    = in_data;
            if (cnt_q == ACT_LAST) begin
              cnt_d   = '0;
              state_d = LOAD_W;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LOAD_W: begin
          in_ready = 1'b1;
          if (in_valid) begin
            dut_W_cen  = 1'b0;
            dut_W_wen  = 1'b0;
            dut_W_addr = cnt_q[6:0];
            dut_W_d    = in_data;
            if (cnt_q == W_LAST) begin
              cnt_d   = '0;
              state_d = KICK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        KICK: begin
          // seq_done is deliberately not looked at here: a stale level from
          // a previous job must not skip the wait.
          seq_begin  = 1'b1;
          dut_cl_sel = 1'b0;
          state_d    = WAIT;
        end
        WAIT: begin
          dut_cl_sel = 1'b0;
          if (seq_done) begin
            cnt_d   = '0;
            state_d = RD_REQ;
          end
        end
        RD_REQ: begin
          dut_OP_cen  = 1'b0;
          dut_OP_addr = OP_BASE9 + cnt_q[8:0];
          state_d     = RD_CAP;
        end
        RD_CAP: begin
          out_data_d  = dut_OP_q;
          out_valid_d = 1'b1;
          state_d     = RD_HOLD;
        end
        RD_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
            state_d     = (cnt_q == OP_LAST) ? FIN : RD_REQ;
          end
        end
        FIN: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign dut_OP_wen = 1'b1;
  assign dut_OP_d   = '0;

endmodule

// File: tb/tb_sram_host_loader.sv
// Bench for sram_host_loader: random load streams and OP contents, checked
// against memory images and an address/data list derived from the rules.
module tb_sram_host_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, seq_done = 1'b0;
  logic [31:0] in_data = '0;
  bit   sel_b = 1'b0;

  logic in_ready_a, out_valid_a, busy_a, done_a, act_cen_a, act_wen_a, w_cen_a, w_wen_a;
  logic op_cen_a, op_wen_a, cl_sel_a, seq_begin_a;
  logic [127:0] out_data_a, op_d_a, op_q_a = '0;
  logic [31:0] act_d_a, w_d_a;
  logic [6:0] act_addr_a, w_addr_a;
  logic [8:0] op_addr_a;

  logic in_ready_b, out_valid_b, busy_b, done_b, act_cen_b, act_wen_b, w_cen_b, w_wen_b;
  logic op_cen_b, op_wen_b, cl_sel_b, seq_begin_b;
  logic [127:0] out_data_b, op_d_b, op_q_b = '0;
  logic [31:0] act_d_b, w_d_b;
  logic [6:0] act_addr_b, w_addr_b;
  logic [8:0] op_addr_b;

  always #5 clk = ~clk;

  sram_host_loader u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a), .dut_ACT_d(act_d_a), .dut_ACT_addr(act_addr_a),
    .dut_ACT_cen(act_cen_a), .dut_ACT_wen(act_wen_a), .dut_W_d(w_d_a), .dut_W_addr(w_addr_a),
    .dut_W_cen(w_cen_a), .dut_W_wen(w_wen_a), .dut_OP_q(op_q_a), .dut_OP_addr(op_addr_a),
    .dut_OP_cen(op_cen_a), .dut_OP_wen(op_wen_a), .dut_OP_d(op_d_a), .dut_cl_sel(cl_sel_a),
    .seq_begin(seq_begin_a), .seq_done(seq_done)
  );

  sram_host_loader #(.OP_BASE(500), .OP_WORDS(20)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .dut_ACT_d(act_d_b), .dut_ACT_addr(act_addr_b),
    .dut_ACT_cen(act_cen_b), .dut_ACT_wen(act_wen_b), .dut_W_d(w_d_b), .dut_W_addr(w_addr_b),
    .dut_W_cen(w_cen_b), .dut_W_wen(w_wen_b), .dut_OP_q(op_q_b), .dut_OP_addr(op_addr_b),
    .dut_OP_cen(op_cen_b), .dut_OP_wen(op_wen_b), .dut_OP_d(op_d_b), .dut_cl_sel(cl_sel_b),
    .seq_begin(seq_begin_b), .seq_done(seq_done)
  );

  // Only one instance runs a job at a time; m_* views the active one.
  wire         m_in_ready  = sel_b ? in_ready_b  : in_ready_a;
  wire         m_out_valid = sel_b ? out_valid_b : out_valid_a;
  wire [127:0] m_out_data  = sel_b ? out_data_b  : out_data_a;
  wire         m_busy      = sel_b ? busy_b      : busy_a;
  wire         m_done      = sel_b ? done_b      : done_a;
  wire [31:0]  m_act_d     = sel_b ? act_d_b     : act_d_a;
  wire [6:0]   m_act_addr  = sel_b ? act_addr_b  : act_addr_a;
  wire         m_act_cen   = sel_b ? act_cen_b   : act_cen_a;
  wire         m_act_wen   = sel_b ? act_wen_b   : act_wen_a;
  wire [31:0]  m_w_d       = sel_b ? w_d_b       : w_d_a;
  wire [6:0]   m_w_addr    = sel_b ? w_addr_b    : w_addr_a;
  wire         m_w_cen     = sel_b ? w_cen_b     : w_cen_a;
  wire         m_w_wen     = sel_b ? w_wen_b     : w_wen_a;
  wire [8:0]   m_op_addr   = sel_b ? op_addr_b   : op_addr_a;
  wire         m_op_cen    = sel_b ? op_cen_b    : op_cen_a;
  wire         m_op_wen    = sel_b ? op_wen_b    : op_wen_a;
  wire [127:0] m_op_d      = sel_b ? op_d_b      : op_d_a;
  wire         m_cl_sel    = sel_b ? cl_sel_b    : cl_sel_a;
  wire         m_seq_begin = sel_b ? seq_begin_b : seq_begin_a;

  wire [354:0] m_vec = {m_in_ready, m_out_valid, m_out_data, m_busy, m_done,
                        m_act_d, m_act_addr, m_act_cen, m_act_wen,
                        m_w_d, m_w_addr, m_w_cen, m_w_wen,
                        m_op_addr, m_op_cen, m_op_wen, m_op_d, m_cl_sel, m_seq_begin};
  localparam logic [354:0] EXP_IDLE = {1'b0, 1'b0, 128'd0, 1'b0, 1'b0,
                                       32'd0, 7'd0, 1'b1, 1'b1,
                                       32'd0, 7'd0, 1'b1, 1'b1,
                                       9'd0, 1'b1, 1'b1, 128'd0, 1'b1, 1'b0};

  // OP SRAM model: registered read, data valid the cycle after the request.
  logic [127:0] op_mem [512];
  always @(posedge clk) begin
    if (!op_cen_a) op_q_a <= op_mem[op_addr_a];
    if (!op_cen_b) op_q_b <= op_mem[op_addr_b];
  end

  // Monitor: SRAM images, read-address list, accepted output words, pulses.
  logic [31:0]  act_mem [128];
  logic [31:0]  w_mem [128];
  logic [8:0]   rd_q [$];
  logic [127:0] out_q [$];
  int act_wr, w_wr, spurious, viol, sb_cnt, cl0_cnt, done_cnt;
  bit clr = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      foreach (act_mem[i]) act_mem[i] = 'x;
      foreach (w_mem[i]) w_mem[i] = 'x;
      rd_q.delete();
      out_q.delete();
      act_wr = 0; w_wr = 0; spurious = 0; viol = 0; sb_cnt = 0; cl0_cnt = 0; done_cnt = 0;
    end else begin
      if (!m_act_cen) begin
        act_mem[m_act_addr] = m_act_d;
        act_wr++;
        if (!in_valid) spurious++;
      end
      if (!m_w_cen) begin
        w_mem[m_w_addr] = m_w_d;
        w_wr++;
        if (!in_valid) spurious++;
      end
      if (m_act_cen !== m_act_wen || m_w_cen !== m_w_wen) viol++;
      if (m_in_ready && in_valid && m_act_cen && m_w_cen) viol++;
      if (m_in_ready && !m_cl_sel) viol++;
      if (m_op_wen !== 1'b1 || m_op_d !== '0) viol++;
      if (!m_op_cen) rd_q.push_back(m_op_addr);
      if (m_out_valid && out_ready) out_q.push_back(m_out_data);
      if (m_seq_begin) begin
        sb_cnt++;
        if (m_cl_sel !== 1'b0) viol++;
      end
      if (!m_cl_sel) cl0_cnt++;
      if (m_done) done_cnt++;
    end
  end

  int passed = 0, total = 0;
  logic [31:0] stim [108];

  task automatic clear_logs();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic feed_words(input bit gaps, input int limit);
    int idx = 0, cyc = 0;
    bit take;
    while (idx < limit && cyc < 4 * limit + 20) begin
      in_valid = !gaps || (cyc % 2 == 1);
      in_data  = in_valid ? stim[idx] : $urandom;
      @(negedge clk);
      take = in_valid && m_in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (idx !== limit) $display("FAIL feed_accept: accepted %0d words, required %0d", idx, limit);
    else passed++;
  endtask

  task automatic corelet(input int delay, input bit start_in_wait);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      seen = m_seq_begin;
      cyc++;
    end
    total++;
    if (!seen) $display("FAIL seq_begin_seen: got 0 within 100 cycles, required 1");
    else passed++;
    @(posedge clk); #1;
    seq_done = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && start_in_wait) start_a = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      start_a = 1'b0;
      in_valid = 1'b0;
    end
    seq_done = 1'b1;
    @(posedge clk); #1;
    seq_done = 1'b0;
  endtask

  task automatic drain(input bit stall, input int n);
    int cyc = 0, k, rd_before;
    bit stalled = 1'b0;
    logic [127:0] held;
    while (out_q.size() < n && cyc < 40 * n) begin
      if (stall && !stalled && out_q.size() == 5) begin
        out_ready = 1'b0;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!m_out_valid && k < 20);
        held = m_out_data;
        rd_before = rd_q.size();
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          total++;
          if (m_out_valid !== 1'b1 || m_out_data !== held)
            $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", m_out_valid, m_out_data, held);
          else passed++;
        end
        total++;
        if (rd_q.size() !== rd_before)
          $display("FAIL stall_no_read: %0d reads during stall, required 0", rd_q.size() - rd_before);
        else passed++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_job(input bit gaps, input bit stall, input int delay,
                         input bit start_in_wait, input bit new_stim);
    int n, base;
    logic [8:0] ea;
    n    = sel_b ? 20 : 64;
    base = sel_b ? 500 : 0;
    if (new_stim) foreach (stim[i]) stim[i] = $urandom;
    clear_logs();
    pulse_start();
    feed_words(gaps, 108);
    corelet(delay, start_in_wait);
    drain(stall, n);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (act_wr !== 36) $display("FAIL act_writes: got %0d, required 36", act_wr); else passed++;
    total++;
    if (w_wr !== 72) $display("FAIL w_writes: got %0d, required 72", w_wr); else passed++;
    for (int i = 0; i < 36; i++) begin
      total++;
      if (act_mem[i] !== stim[i]) $display("FAIL act_mem[%0d]: got %h, required %h", i, act_mem[i], stim[i]);
      else passed++;
    end
    for (int i = 0; i < 72; i++) begin
      total++;
      if (w_mem[i] !== stim[36+i]) $display("FAIL w_mem[%0d]: got %h, required %h", i, w_mem[i], stim[36+i]);
      else passed++;
    end
    total++;
    if (spurious !== 0 || viol !== 0) $display("FAIL protocol: spurious=%0d viol=%0d, required 0 0", spurious, viol);
    else passed++;
    total++;
    if (sb_cnt !== 1) $display("FAIL seq_begin_count: got %0d, required 1", sb_cnt); else passed++;
    total++;
    if (cl0_cnt !== delay + 2) $display("FAIL cl_sel_low_cycles: got %0d, required %0d", cl0_cnt, delay + 2);
    else passed++;
    total++;
    if (rd_q.size() !== n || out_q.size() !== n)
      $display("FAIL op_counts: reads=%0d words=%0d, required %0d", rd_q.size(), out_q.size(), n);
    else passed++;
    for (int i = 0; i < n && i < rd_q.size() && i < out_q.size(); i++) begin
      ea = 9'((base + i) % 512);
      total++;
      if (rd_q[i] !== ea || out_q[i] !== op_mem[ea])
        $display("FAIL op_word[%0d]: addr=%0d data=%h, required addr=%0d data=%h", i, rd_q[i], out_q[i], ea, op_mem[ea]);
      else passed++;
    end
    total++;
    if (done_cnt !== 1 || m_busy !== 1'b0)
      $display("FAIL job_end: done pulses=%0d busy=%b, required 1 0", done_cnt, m_busy);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (m_vec !== EXP_IDLE) $display("FAIL reset_held: got %h, required %h", m_vec, EXP_IDLE); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (m_vec !== EXP_IDLE) $display("FAIL reset_release: got %h, required %h", m_vec, EXP_IDLE); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    run_job(1'b0, 1'b0, 4, 1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    run_job(1'b1, 1'b0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_out_stall();
    run_job(1'b0, 1'b1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_op_wrap();
    sel_b = 1'b1;
    run_job(1'b0, 1'b0, 2, 1'b0, 1'b1);
    sel_b = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    foreach (stim[i]) stim[i] = $urandom;
    clear_logs();
    pulse_start();
    feed_words(1'b0, 66);
    in_valid = 1'b1;
    in_data  = $urandom;
    reset    = 1'b1;
    @(negedge clk);
    total++;
    if (m_w_cen !== 1'b1 || m_act_cen !== 1'b1)
      $display("FAIL reset_cycle_access: act_cen=%b w_cen=%b, required 1 1", m_act_cen, m_w_cen);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (m_vec !== EXP_IDLE) $display("FAIL reset_mid_load: got %h, required %h", m_vec, EXP_IDLE); else passed++;
    total++;
    if (act_wr !== 36 || w_wr !== 66 - 36 || done_cnt !== 0)
      $display("FAIL reset_abort: act=%0d w=%0d done=%0d, required 36 30 0", act_wr, w_wr, done_cnt);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    run_job(1'b0, 1'b0, 3, 1'b0, 1'b1);
  endtask

  task automatic test_seq_done_early();
    seq_done = 1'b1;
    run_job(1'b0, 1'b0, 5, 1'b1, 1'b1);
  endtask

  initial begin
    foreach (op_mem[i]) op_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_nominal();
    test_gaps();
    test_out_stall();
    test_op_wrap();
    test_reset_mid_load();
    test_seq_done_early();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
